// File: rtl/glb_bank_packet_arb_pkg.sv
// Shared types and default widths for the bank packet arbiter.
package glb_bank_packet_arb_pkg;

  localparam int GLB_BANK_ADDR_W = 17;
  localparam int GLB_BANK_DATA_W = 64;
  localparam int GLB_RD_LATENCY  = 3;
  localparam int GLB_MAX_STALL   = 8;

  typedef enum logic {PROC = 1'b0, STRM = 1'b1} arb_src_e;
  typedef enum logic {NORMAL = 1'b0, BOOST = 1'b1} arb_state_e;

  typedef struct packed {
    logic     valid;
    arb_src_e src;
  } rd_tag_t;

endpackage

// File: rtl/glb_rd_tag_pipe.sv
// Read-tag delay line: carries {valid, src} alongside the bank read pipeline.
module glb_rd_tag_pipe
  import glb_bank_packet_arb_pkg::*;
#(
  parameter int DEPTH = GLB_RD_LATENCY
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_i,
  output rd_tag_t tail_o
);

  rd_tag_t [DEPTH-1:0] tag_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tail_o = tag_q[DEPTH-1];

endmodule

// File: rtl/glb_bank_packet_arb.sv
// Merges proc/strm packet requesters onto one bank port and routes read responses.
// Optional GLB_BANK_ARB_PERF_CNT_EN adds saturating grant/stall/boost counters.
module glb_bank_packet_arb
  import glb_bank_packet_arb_pkg::*;
#(
  parameter int BANK_ADDR_WIDTH = GLB_BANK_ADDR_W,
  parameter int BANK_DATA_WIDTH = GLB_BANK_DATA_W,
  parameter int RD_LATENCY      = GLB_RD_LATENCY,
  parameter int MAX_STALL       = GLB_MAX_STALL
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       proc_wr_en,
  input  logic [BANK_ADDR_WIDTH-1:0] proc_wr_addr,
  input  logic [BANK_DATA_WIDTH-1:0] proc_wr_data,
  input  logic [BANK_DATA_WIDTH-1:0] proc_wr_data_bit_sel,
  input  logic                       proc_rd_en,
  input  logic [BANK_ADDR_WIDTH-1:0] proc_rd_addr,
  output logic                       proc_ready,
  output logic [BANK_DATA_WIDTH-1:0] proc_rd_data,
  output logic                       proc_rd_data_valid,
  input  logic                       strm_wr_en,
  input  logic [BANK_ADDR_WIDTH-1:0] strm_wr_addr,
  input  logic [BANK_DATA_WIDTH-1:0] strm_wr_data,
  input  logic [BANK_DATA_WIDTH-1:0] strm_wr_data_bit_sel,
  input  logic                       strm_rd_en,
  input  logic [BANK_ADDR_WIDTH-1:0] strm_rd_addr,
  output logic                       strm_ready,
  output logic [BANK_DATA_WIDTH-1:0] strm_rd_data,
  output logic                       strm_rd_data_valid,
  input  logic                       cfg_sram_busy,
  output logic                       packet_wr_en,
  output logic [BANK_ADDR_WIDTH-1:0] packet_wr_addr,
  output logic [BANK_DATA_WIDTH-1:0] packet_wr_data,
  output logic [BANK_DATA_WIDTH-1:0] packet_wr_data_bit_sel,
  output logic                       packet_rd_en,
  output logic [BANK_ADDR_WIDTH-1:0] packet_rd_addr,
  input  logic [BANK_DATA_WIDTH-1:0] packet_rd_data,
  input  logic                       packet_rd_data_valid,
`ifdef GLB_BANK_ARB_PERF_CNT_EN
  output logic [31:0]                perf_proc_grant,
  output logic [31:0]                perf_strm_grant,
  output logic [31:0]                perf_cfg_stall,
  output logic [31:0]                perf_boost,
`endif
  output logic                       err_orphan_rsp
);

  localparam int SW = $clog2(MAX_STALL + 1);

  logic       proc_req, strm_req, blocked;
  logic       gnt_proc, gnt_strm;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  arb_state_e state_q, state_d;
  rd_tag_t    tag_in, tag_tail;

  logic [BANK_DATA_WIDTH-1:0] proc_rd_data_q, strm_rd_data_q;
  logic proc_rd_vld_q, strm_rd_vld_q, err_q;

  assign proc_req = proc_wr_en | proc_rd_en;
  assign strm_req = strm_wr_en | strm_rd_en;
  // Reset gates grants so every output reads 0 while reset is held.
  assign blocked  = cfg_sram_busy | ~reset;

  always_comb begin
    gnt_proc = 1'b0;
    gnt_strm = 1'b0;
    if (!blocked) begin
      if (state_q == BOOST && strm_req) gnt_strm = 1'b1;
      else if (proc_req)                gnt_proc = 1'b1;
      else if (strm_req)                gnt_strm = 1'b1;
    end
  end

  assign proc_ready = gnt_proc | (~blocked & ~proc_req);
  assign strm_ready = gnt_strm;

  // Write has priority over a simultaneous read from the same requester.
  always_comb begin
    packet_wr_en           = 1'b0;
    packet_wr_addr         = '0;
    packet_wr_data         = '0;
    packet_wr_data_bit_sel = '0;
    packet_rd_en           = 1'b0;
    packet_rd_addr         = '0;
    if (gnt_proc) begin
      if (proc_wr_en) begin
        packet_wr_en           = 1'b1;
        packet_wr_addr         = proc_wr_addr;
        packet_wr_data         = proc_wr_data;
        packet_wr_data_bit_sel = proc_wr_data_bit_sel;
      end else begin
        packet_rd_en   = 1'b1;
        packet_rd_addr = proc_rd_addr;
      end
    end else if (gnt_strm) begin
      if (strm_wr_en) begin
        packet_wr_en           = 1'b1;
        packet_wr_addr         = strm_wr_addr;
        packet_wr_data         = strm_wr_data;
        packet_wr_data_bit_sel = strm_wr_data_bit_sel;
      end else begin
        packet_rd_en   = 1'b1;
        packet_rd_addr = strm_rd_addr;
      end
    end
  end

  // Boost is decided from the next count so strm wins right after its MAX_STALL-th loss.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    state_d     = state_q;
    if (gnt_strm || !strm_req)                     stall_cnt_d = '0;
    else if (!cfg_sram_busy && stall_cnt_q != SW'(MAX_STALL))
                                                   stall_cnt_d = stall_cnt_q + SW'(1);
    case (state_q)
      NORMAL:  if (stall_cnt_d == SW'(MAX_STALL)) state_d = BOOST;
      BOOST:   if (gnt_strm || !strm_req)         state_d = NORMAL;
      default:                                    state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      state_q     <= NORMAL;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      state_q     <= state_d;
    end
  end

  assign tag_in.valid = packet_rd_en;
  assign tag_in.src   = gnt_strm ? STRM : PROC;

  glb_rd_tag_pipe #(.DEPTH(RD_LATENCY)) u_tag_pipe (
    .clk    (clk),
    .reset  (reset),
    .tag_i  (tag_in),
    .tail_o (tag_tail)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      proc_rd_data_q <= '0;
      strm_rd_data_q <= '0;
      proc_rd_vld_q  <= 1'b0;
      strm_rd_vld_q  <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      proc_rd_vld_q <= 1'b0;
      strm_rd_vld_q <= 1'b0;
      if (packet_rd_data_valid) begin
        if (!tag_tail.valid) begin
          err_q <= 1'b1;
        end else if (tag_tail.src == STRM) begin
          strm_rd_data_q <= packet_rd_data;
          strm_rd_vld_q  <= 1'b1;
        end else begin
          proc_rd_data_q <= packet_rd_data;
          proc_rd_vld_q  <= 1'b1;
        end
      end
    end
  end

  assign proc_rd_data       = proc_rd_data_q;
  assign proc_rd_data_valid = proc_rd_vld_q;
  assign strm_rd_data       = strm_rd_data_q;
  assign strm_rd_data_valid = strm_rd_vld_q;
  assign err_orphan_rsp     = err_q;

`ifdef GLB_BANK_ARB_PERF_CNT_EN
  logic [31:0] perf_proc_q, perf_strm_q, perf_cfg_q, perf_boost_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_proc_q  <= '0;
      perf_strm_q  <= '0;
      perf_cfg_q   <= '0;
      perf_boost_q <= '0;
    end else begin
      if (gnt_proc && perf_proc_q != '1) perf_proc_q <= perf_proc_q + 32'd1;
      if (gnt_strm && perf_strm_q != '1) perf_strm_q <= perf_strm_q + 32'd1;
      if (cfg_sram_busy && (proc_req || strm_req) && perf_cfg_q != '1)
        perf_cfg_q <= perf_cfg_q + 32'd1;
      if (state_q == NORMAL && state_d == BOOST && perf_boost_q != '1)
        perf_boost_q <= perf_boost_q + 32'd1;
    end
  end

  assign perf_proc_grant = perf_proc_q;
  assign perf_strm_grant = perf_strm_q;
  assign perf_cfg_stall  = perf_cfg_q;
  assign perf_boost      = perf_boost_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(proc_wr_en && proc_rd_en)) else $error("proc wr_en and rd_en both high");
      assert (!(strm_wr_en && strm_rd_en)) else $error("strm wr_en and rd_en both high");
    end
  end
`endif

endmodule

// File: tb/tb_glb_bank_packet_arb.sv
// Directed bench for glb_bank_packet_arb with a fixed-latency bank read model.
module tb_glb_bank_packet_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        proc_wr_en, proc_rd_en, strm_wr_en, strm_rd_en;
  logic [16:0] proc_wr_addr, proc_rd_addr, strm_wr_addr, strm_rd_addr;
  logic [63:0] proc_wr_data, proc_wr_data_bit_sel, strm_wr_data, strm_wr_data_bit_sel;
  logic        proc_ready, strm_ready, proc_rd_data_valid, strm_rd_data_valid;
  logic [63:0] proc_rd_data, strm_rd_data;
  logic        cfg_sram_busy;
  logic        packet_wr_en, packet_rd_en, packet_rd_data_valid;
  logic [16:0] packet_wr_addr, packet_rd_addr;
  logic [63:0] packet_wr_data, packet_wr_data_bit_sel, packet_rd_data;
  logic        err_orphan_rsp;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  glb_bank_packet_arb dut (
    .clk(clk), .reset(reset),
    .proc_wr_en(proc_wr_en), .proc_wr_addr(proc_wr_addr), .proc_wr_data(proc_wr_data),
    .proc_wr_data_bit_sel(proc_wr_data_bit_sel), .proc_rd_en(proc_rd_en), .proc_rd_addr(proc_rd_addr),
    .proc_ready(proc_ready), .proc_rd_data(proc_rd_data), .proc_rd_data_valid(proc_rd_data_valid),
    .strm_wr_en(strm_wr_en), .strm_wr_addr(strm_wr_addr), .strm_wr_data(strm_wr_data),
    .strm_wr_data_bit_sel(strm_wr_data_bit_sel), .strm_rd_en(strm_rd_en), .strm_rd_addr(strm_rd_addr),
    .strm_ready(strm_ready), .strm_rd_data(strm_rd_data), .strm_rd_data_valid(strm_rd_data_valid),
    .cfg_sram_busy(cfg_sram_busy),
    .packet_wr_en(packet_wr_en), .packet_wr_addr(packet_wr_addr), .packet_wr_data(packet_wr_data),
    .packet_wr_data_bit_sel(packet_wr_data_bit_sel), .packet_rd_en(packet_rd_en),
    .packet_rd_addr(packet_rd_addr), .packet_rd_data(packet_rd_data),
    .packet_rd_data_valid(packet_rd_data_valid), .err_orphan_rsp(err_orphan_rsp)
  );

  // Bank model: 3-cycle read pipeline that ignores the arbiter's reset.
  logic [2:0]       b_en = '0;
  logic [2:0][16:0] b_addr = '0;

  function automatic logic [63:0] bank_val(input logic [16:0] a);
    return (a == 17'h100) ? 64'hDEAD : {32'hC0DE0000, 15'b0, a};
  endfunction

  always @(posedge clk) begin
    b_en   <= {b_en[1:0], packet_rd_en};
    b_addr <= {b_addr[1:0], packet_rd_addr};
  end

  assign packet_rd_data_valid = b_en[2];
  assign packet_rd_data       = b_en[2] ? bank_val(b_addr[2]) : 64'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    proc_wr_en = 0; proc_rd_en = 0; strm_wr_en = 0; strm_rd_en = 0;
    proc_wr_addr = 0; proc_rd_addr = 0; strm_wr_addr = 0; strm_rd_addr = 0;
    proc_wr_data = 0; proc_wr_data_bit_sel = 0; strm_wr_data = 0; strm_wr_data_bit_sel = 0;
    cfg_sram_busy = 0;

    // Reset state
    step(); step(); #1;
    chk("rst_proc_rdy", proc_ready, 0);
    chk("rst_strm_rdy", strm_ready, 0);
    chk("rst_wr_en", packet_wr_en, 0);
    chk("rst_rd_en", packet_rd_en, 0);
    chk("rst_pvld", proc_rd_data_valid, 0);
    chk("rst_pdata", proc_rd_data, 0);
    chk("rst_err", err_orphan_rsp, 0);
    reset = 1'b1;
    step();

    // Same-cycle writes: proc first, strm next cycle
    proc_wr_en = 1; proc_wr_addr = 17'h40; proc_wr_data = 64'hA5; proc_wr_data_bit_sel = '1;
    strm_wr_en = 1; strm_wr_addr = 17'h80; strm_wr_data = 64'h5A; strm_wr_data_bit_sel = '1;
    #1;
    chk("w1_en", packet_wr_en, 1);
    chk("w1_addr", packet_wr_addr, 64'h40);
    chk("w1_data", packet_wr_data, 64'hA5);
    chk("w1_prdy", proc_ready, 1);
    chk("w1_srdy", strm_ready, 0);
    step();
    proc_wr_en = 0; #1;
    chk("w2_addr", packet_wr_addr, 64'h80);
    chk("w2_data", packet_wr_data, 64'h5A);
    chk("w2_srdy", strm_ready, 1);
    chk("w2_prdy_idle", proc_ready, 1);
    step();
    strm_wr_en = 0;

    // proc read, 4-cycle response latency
    proc_rd_en = 1; proc_rd_addr = 17'h100; #1;
    chk("r_en", packet_rd_en, 1);
    chk("r_addr", packet_rd_addr, 64'h100);
    step(); proc_rd_en = 0;
    step(); step(); #1;
    chk("r_early", proc_rd_data_valid, 0);
    step(); #1;
    chk("r_pvld", proc_rd_data_valid, 1);
    chk("r_pdata", proc_rd_data, 64'hDEAD);
    chk("r_svld", strm_rd_data_valid, 0);
    step(); #1;
    chk("r_pvld_off", proc_rd_data_valid, 0);
    chk("r_hold", proc_rd_data, 64'hDEAD);

    // Starvation: strm boosted after 8 lost cycles
    proc_wr_en = 1; proc_wr_addr = 17'h44; proc_wr_data = 64'h1;
    strm_rd_en = 1; strm_rd_addr = 17'h200;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("stl_lose", strm_ready, 0);
      step();
    end
    #1;
    chk("stl_srdy", strm_ready, 1);
    chk("stl_prdy", proc_ready, 0);
    chk("stl_rd_en", packet_rd_en, 1);
    chk("stl_rd_addr", packet_rd_addr, 64'h200);
    chk("stl_wr_en", packet_wr_en, 0);
    step(); #1;
    chk("stl_normal", strm_ready, 0);
    chk("stl_normal_p", proc_ready, 1);
    strm_rd_en = 0; proc_wr_en = 0;
    step(); step(); step(); #1;
    chk("stl_svld", strm_rd_data_valid, 1);
    chk("stl_sdata", strm_rd_data, 64'hC0DE0000_00000200);
    chk("stl_pvld", proc_rd_data_valid, 0);
    step();

    // cfg_sram_busy blocks both for 5 cycles
    proc_wr_en = 1; proc_wr_addr = 17'h48; strm_rd_en = 1; strm_rd_addr = 17'h210;
    cfg_sram_busy = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("cfg_prdy", proc_ready, 0);
      chk("cfg_srdy", strm_ready, 0);
      chk("cfg_wr_en", packet_wr_en, 0);
      chk("cfg_rd_en", packet_rd_en, 0);
      step();
    end
    cfg_sram_busy = 0; #1;
    chk("cfg_res_prdy", proc_ready, 1);
    chk("cfg_res_wr", packet_wr_en, 1);
    chk("cfg_res_addr", packet_wr_addr, 64'h48);
    chk("cfg_res_srdy", strm_ready, 0);
    proc_wr_en = 0; strm_rd_en = 0;
    step();

    // Alternating reads, responses in order
    proc_rd_en = 1; proc_rd_addr = 17'h10; #1;
    chk("alt0_addr", packet_rd_addr, 64'h10);
    step(); proc_rd_en = 0; strm_rd_en = 1; strm_rd_addr = 17'h20; #1;
    chk("alt1_srdy", strm_ready, 1);
    chk("alt1_addr", packet_rd_addr, 64'h20);
    step(); strm_rd_en = 0; proc_rd_en = 1; proc_rd_addr = 17'h30; #1;
    chk("alt2_addr", packet_rd_addr, 64'h30);
    step(); proc_rd_en = 0; strm_rd_en = 1; strm_rd_addr = 17'h40; #1;
    chk("alt3_addr", packet_rd_addr, 64'h40);
    step(); strm_rd_en = 0; #1;
    chk("alt0_pvld", proc_rd_data_valid, 1);
    chk("alt0_pdata", proc_rd_data, 64'hC0DE0000_00000010);
    chk("alt0_svld", strm_rd_data_valid, 0);
    step(); #1;
    chk("alt1_svld", strm_rd_data_valid, 1);
    chk("alt1_sdata", strm_rd_data, 64'hC0DE0000_00000020);
    chk("alt1_pvld", proc_rd_data_valid, 0);
    step(); #1;
    chk("alt2_pvld", proc_rd_data_valid, 1);
    chk("alt2_pdata", proc_rd_data, 64'hC0DE0000_00000030);
    step(); #1;
    chk("alt3_svld", strm_rd_data_valid, 1);
    chk("alt3_sdata", strm_rd_data, 64'hC0DE0000_00000040);
    step(); #1;
    chk("alt_end_p", proc_rd_data_valid, 0);
    chk("alt_end_s", strm_rd_data_valid, 0);
    chk("alt_err", err_orphan_rsp, 0);

    // Reset mid-flight: response becomes an orphan
    step();
    proc_rd_en = 1; proc_rd_addr = 17'h300; #1;
    chk("orp_issue", packet_rd_en, 1);
    step(); proc_rd_en = 0; reset = 0; #1;
    chk("orp_rst_rdy", proc_ready, 0);
    chk("orp_rst_rd", packet_rd_en, 0);
    step(); reset = 1; #1;
    chk("orp_err_pre", err_orphan_rsp, 0);
    step(); step(); #1;
    chk("orp_pvld", proc_rd_data_valid, 0);
    chk("orp_pdata", proc_rd_data, 0);
    chk("orp_err", err_orphan_rsp, 1);
    step(); step(); step(); #1;
    chk("orp_sticky", err_orphan_rsp, 1);
    reset = 0;
    step(); #1;
    chk("orp_clr", err_orphan_rsp, 0);
    reset = 1;
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
